// File: rtl/rx_cmd_pkg.sv
// Shared constants for the UART rate-command parser: ASCII bytes of the
// "rate:<c>" grammar, rate codes and the parser state encoding.
package rx_cmd_pkg;

    // Keyword bytes of "rate:"
    localparam logic [7:0] CH_R     = 8'h72;
    localparam logic [7:0] CH_A     = 8'h61;
    localparam logic [7:0] CH_T     = 8'h74;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_COLON = 8'h3A;

    // Separators and terminators
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_SPACE = 8'h20;

    // Argument bytes
    localparam logic [7:0] ARG_1    = 8'h31;
    localparam logic [7:0] ARG_5    = 8'h35;
    localparam logic [7:0] ARG_A    = 8'h61;

    // Rate codes reported to the rate-control logic
    localparam logic [1:0] RATE_1   = 2'b00;
    localparam logic [1:0] RATE_5   = 2'b01;
    localparam logic [1:0] RATE_A   = 2'b10;

    // Index of the final keyword byte (':')
    localparam logic [2:0] KEY_LAST = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEY,
        ST_ARG,
        ST_TERM
    } state_t;

    // Expected keyword byte at a given match position
    function automatic logic [7:0] keyword_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return CH_R;
            3'd1:    return CH_A;
            3'd2:    return CH_T;
            3'd3:    return CH_E;
            default: return CH_COLON;
        endcase
    endfunction

endpackage

// File: rtl/rx_cmd_timeout.sv
// Inter-byte timeout for the command parser. Counts idle cycles while a
// command is open and flags expiry for exactly one cycle.
module rx_cmd_timeout #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TW             = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    // Clear wins over expiry so a byte arriving on the last cycle is never an error
    assign expire = enable && !clear && (count == LAST);

    // Idle-cycle counter; wraps to zero on expiry
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) count <= '0;
            else               count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/rx_rate_cmd_parser.sv
// Receive-side decoder for "rate:<c>" commands terminated by CR or LF.
// Drives the 2-bit rate code and one-cycle valid/error pulses.
module rx_rate_cmd_parser
    import rx_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TW             = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] iRX_DATA,
    input  logic       iRX_VALID,
    output logic [1:0] oRATE,
    output logic       oRATE_VALID,
    output logic       oCMD_ERR,
    output logic       oBUSY
);

    state_t     state, state_n;
    logic [2:0] idx, idx_n;
    logic [1:0] pend, pend_n;
    logic [1:0] rate_n;
    logic       rate_valid_n, cmd_err_n;
    logic       expire;

    rx_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TW             (TW)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (iRX_VALID || (state == ST_IDLE)),
        .enable (1'b1),
        .expire (expire)
    );

    // Next-state, keyword index, pending code and output decode
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_n      = state;
        idx_n        = idx;
        pend_n       = pend;
        rate_n       = oRATE;
        rate_valid_n = 1'b0;
        cmd_err_n    = 1'b0;

        if (iRX_VALID) begin
            unique case (state)
                ST_IDLE: begin
                    if (iRX_DATA == CH_R) begin
                        state_n = ST_KEY;
                        idx_n   = 3'd1;
                    end else if (iRX_DATA != CH_SPACE && iRX_DATA != CH_CR &&
                                 iRX_DATA != CH_LF) begin
                        cmd_err_n = 1'b1;
                    end
                end
                ST_KEY: begin
                    if (iRX_DATA == keyword_byte(idx)) begin
                        if (idx == KEY_LAST) begin
                            state_n = ST_ARG;
                            idx_n   = 3'd0;
                        end else begin
                            idx_n   = idx + 3'd1;
                        end
                    end else begin
                        cmd_err_n = 1'b1;
                        if (iRX_DATA == CH_R) begin
                            state_n = ST_KEY;
                            idx_n   = 3'd1;
                        end else begin
                            state_n = ST_IDLE;
                            idx_n   = 3'd0;
                        end
                    end
                end
                ST_ARG: begin
                    state_n = ST_TERM;
                    if (iRX_DATA == ARG_1)      pend_n = RATE_1;
                    else if (iRX_DATA == ARG_5) pend_n = RATE_5;
                    else if (iRX_DATA == ARG_A) pend_n = RATE_A;
                    else begin
                        cmd_err_n = 1'b1;
                        state_n   = ST_IDLE;
                    end
                end
                ST_TERM: begin
                    state_n = ST_IDLE;
                    if (iRX_DATA == CH_CR || iRX_DATA == CH_LF) begin
                        rate_n       = pend;
                        rate_valid_n = 1'b1;
                    end else begin
                        cmd_err_n    = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (expire) begin
            state_n   = ST_IDLE;
            idx_n     = 3'd0;
            pend_n    = RATE_1;
            cmd_err_n = 1'b1;
        end
    end

    // State, index, pending code and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= 3'd0;
            pend        <= RATE_1;
            oRATE       <= RATE_1;
            oRATE_VALID <= 1'b0;
            oCMD_ERR    <= 1'b0;
            oBUSY       <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            pend        <= pend_n;
            oRATE       <= rate_n;
            oRATE_VALID <= rate_valid_n;
            oCMD_ERR    <= cmd_err_n;
            oBUSY       <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: doc/rx_rate_cmd_parser.md
# rx_rate_cmd_parser

Receive-side command decoder for the UART rate-control link. Consumes the byte stream from the UART receiver, recognises ASCII commands of the form `rate:<c>` terminated by CR or LF, and drives the 2-bit rate code that the rate-status transmit path reports back. Sits between the UART RX deserializer and the rate-control logic.

## Interface
- TIMEOUT_CYCLES, default 50_000_000: idle cycles allowed between bytes of one command before it is abandoned (1 s at 50 MHz).
- TW, default 26: timeout counter width; must satisfy 2^TW > TIMEOUT_CYCLES.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- iRX_DATA  in  8  received byte, valid only when iRX_VALID=1.
- iRX_VALID  in  1  one-cycle strobe per received byte; may be asserted on consecutive cycles.
- oRATE  out  2  current rate code: 2'b00 = '1', 2'b01 = '5', 2'b10 = 'a'; 2'b11 never driven.
- oRATE_VALID  out  1  one-cycle pulse when oRATE is loaded by a complete, valid command.
- oCMD_ERR  out  1  one-cycle pulse on a malformed or timed-out command.
- oBUSY  out  1  high while a command is partially received (state not IDLE).

## Operation
- States: IDLE, KEY (matching "rate:"; 3-bit index 0..4), ARG (awaiting argument byte), TERM (awaiting terminator).
- IDLE: 'r' (0x72) -> KEY with index=1. Space (0x20), CR (0x0D), LF (0x0A) are ignored. Any other byte -> oCMD_ERR pulse, stay IDLE.
- KEY: byte equals keyword[index] ("rate:" = 72 61 74 65 3A) -> index+1; after ':' matched -> ARG. Mismatch -> oCMD_ERR pulse; if the mismatching byte is 'r', go to KEY with index=1 (resync), else IDLE.
- ARG: '1' (0x31) / '5' (0x35) / 'a' (0x61) latched into the pending code 00/01/10 -> TERM. Any other byte -> oCMD_ERR, IDLE.
- TERM: CR or LF -> oRATE <= pending code, oRATE_VALID pulse, IDLE. Any other byte -> oCMD_ERR, IDLE; oRATE unchanged.
- Matching is case-sensitive; uppercase letters are mismatches.
- Timeout: counter clears on every iRX_VALID and while in IDLE; counts otherwise. Reaching TIMEOUT_CYCLES-1 -> oCMD_ERR pulse, IDLE, index cleared, pending code discarded.
- oRATE changes only on a valid terminator; errors never alter it.

## Timing
- Reset values: oRATE=2'b00, oRATE_VALID=0, oCMD_ERR=0, oBUSY=0, state IDLE, index 0, timer 0.
- All outputs registered. oRATE/oRATE_VALID update on the edge after the cycle in which the terminator is strobed (latency 1). oCMD_ERR likewise 1 cycle after the offending byte or timeout-expiry cycle.
- oRATE_VALID and oCMD_ERR are never high in the same cycle.
- Back-to-back bytes (iRX_VALID every cycle) accepted without loss; throughput 1 byte/cycle.
- iRX_VALID in the same cycle the timer would expire: byte wins, processed normally, timer cleared, no error.
- reset asserted mid-command: immediate return to reset values; partial command lost; first byte after deassertion parsed from IDLE.
- iRX_DATA ignored when iRX_VALID=0.

## Structure
- Package rx_cmd_pkg: keyword byte constants (R,A,T,E,COLON), CR/LF/SPACE, argument bytes, rate-code constants RATE_1/RATE_5/RATE_A, FSM state encoding.
- Sub-module rx_cmd_timeout: TW-bit counter with clear/enable inputs and one-cycle expire output, parameterised by TIMEOUT_CYCLES.
- Top holds FSM, keyword index, pending-code register, output registers.

## Test plan
- Reset, then "rate:5\r" on consecutive cycles -> oRATE_VALID one pulse 1 cycle after CR, oRATE=2'b01, no oCMD_ERR.
- "rate:a\n" then "rate:1\r" spaced 10 cycles apart -> oRATE 2'b10 then 2'b00, two oRATE_VALID pulses.
- "rarate:5\r" -> one oCMD_ERR at 2nd 'r'? no: at 'r' after "ra" (mismatch, resync) -> then valid command, oRATE=2'b01.
- "rate:7\r" and "rate:5x" -> oCMD_ERR on '7' and on 'x'; oRATE stays at prior value, no oRATE_VALID.
- TIMEOUT_CYCLES=16: "rat" then silence -> oCMD_ERR exactly once, oBUSY falls; byte arriving on expiry cycle instead -> no error.
- Reset pulsed after "rate:" -> outputs at reset values; subsequent "rate:a\r" -> oRATE=2'b10.
